// File: rtl/usb_pkg.sv
// Shared USB link-layer constants: CRC16 parameters and DATA PID codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package usb_pkg;

  // Reflected CRC16 (x^16+x^15+x^2+1), processed LSB first.
  localparam logic [15:0] CRC16_INIT       = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R     = 16'hA001;
  // Register value left after running a correct packet's own CRC bytes through.
  localparam logic [15:0] CRC16_RESIDUAL_R = 16'hB001;

  typedef enum logic [7:0] {
    PID_DATA0 = 8'hC3,
    PID_DATA1 = 8'h4B,
    PID_DATA2 = 8'h87,
    PID_MDATA = 8'h0F
  } pid_e;

endpackage

// File: rtl/crc16_strip_r_if.sv
// Byte-stream handshake bundle around the CRC16 strip stage (input and output side).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; a beat moves when valid & ready.
interface crc16_strip_r_if #(
  parameter int CNT_W = 11
);
  logic             in_sop;
  logic             in_eop;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_sop;
  logic             out_eop;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_err;
  logic [CNT_W-1:0] pkt_len;

  // Upstream byte source plus downstream sink, i.e. the environment of the stage.
  modport master (
    output in_sop, in_eop, in_valid, in_data, out_ready,
    input  in_ready, out_sop, out_eop, out_valid, out_data, out_err, pkt_len
  );

  // The strip stage itself.
  modport slave (
    input  in_sop, in_eop, in_valid, in_data, out_ready,
    output in_ready, out_sop, out_eop, out_valid, out_data, out_err, pkt_len
  );
endinterface

// File: rtl/crc16_byte_r.sv
// One-byte update of the reflected USB CRC16, eight shift steps unrolled.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the result.
module crc16_byte_r
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // Fold the byte into the low bits, then shift right eight times LSB first.
  always_comb begin
    crc_out = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC16_POLY_R) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/crc16_strip_r.sv
// RX DATA packet stage: checks CRC16, strips the two CRC bytes, flags errors on EOP.
// Latency: a byte leaves the output register 2 accepted bytes after it entered.
// Backpressure: out_ready stalls the output register; in_ready drops once the 2-byte buffer is full.
module crc16_strip_r
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1023,
  parameter int CNT_W       = 11
) (
  input logic            clk,
  input logic            rst,
  crc16_strip_r_if.slave io
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  logic [1:0]       state;
  logic [7:0]       b0;
  logic [7:0]       b1;
  logic [1:0]       buf_cnt;
  logic [15:0]      crc;
  logic [15:0]      crc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] len_nxt;
  logic             emitted;   // some byte of the current packet already left the stage

  logic             out_valid_q;
  logic             out_sop_q;
  logic             out_eop_q;
  logic             out_err_q;
  logic [7:0]       out_data_q;
  logic [CNT_W-1:0] pkt_len_q;

  logic             out_ld;
  logic             abort_req;
  logic             acc;
  logic             crc_good;
  logic             len_over;

  crc16_byte_r u_crc (
    .crc_in  (crc),
    .data    (io.in_data),
    .crc_out (crc_nxt)
  );

  assign out_ld    = !out_valid_q || io.out_ready;
  // A new sop after bytes went downstream must first close the old packet, so hold it off.
  assign abort_req = (state == ST_RUN) && io.in_valid && io.in_sop && emitted;
  assign io.in_ready = ((state == ST_RUN) || (state == ST_IDLE)) &&
                       ((buf_cnt < 2'd2) || out_ld) && !abort_req;
  assign acc       = io.in_valid && io.in_ready;
  assign cnt_nxt   = cnt + CNT_W'(1);
  // The two CRC bytes are counted too; strip them from the reported length.
  assign len_nxt   = cnt_nxt - CNT_W'(2);
  assign crc_good  = (crc_nxt == CRC16_RESIDUAL_R);
  assign len_over  = (len_nxt > CNT_W'(MAX_PAYLOAD));

  assign io.out_valid = out_valid_q;
  assign io.out_sop   = out_sop_q;
  assign io.out_eop   = out_eop_q;
  assign io.out_err   = out_err_q;
  assign io.out_data  = out_data_q;
  assign io.pkt_len   = pkt_len_q;

  // Packet FSM, 2-byte delay buffer, CRC/count accumulation and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      b0          <= '0;
      b1          <= '0;
      buf_cnt     <= '0;
      crc         <= CRC16_INIT;
      cnt         <= '0;
      emitted     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
      pkt_len_q   <= '0;
    end else begin
      if (out_ld) out_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Only a sop byte opens a packet; sop+eop on one byte is a runt.
          if (acc && io.in_sop && !io.in_eop) begin
            b0      <= io.in_data;
            buf_cnt <= 2'd1;
            crc     <= CRC16_INIT;
            cnt     <= '0;
            emitted <= 1'b0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            state <= ST_ABORT;
          end else if (acc && io.in_sop) begin
            // Nothing left yet: restart on the new PID in place.
            b0      <= io.in_data;
            buf_cnt <= 2'd1;
            crc     <= CRC16_INIT;
            cnt     <= '0;
            if (io.in_eop) begin
              buf_cnt <= '0;
              state   <= ST_IDLE;
            end
          end else if (acc) begin
            crc <= crc_nxt;
            cnt <= cnt_nxt;
            if (buf_cnt == 2'd2) begin
              out_valid_q <= 1'b1;
              out_data_q  <= b0;
              out_sop_q   <= !emitted;
              out_eop_q   <= io.in_eop;
              out_err_q   <= io.in_eop && (!crc_good || len_over);
              pkt_len_q   <= io.in_eop ? len_nxt : '0;
              emitted     <= 1'b1;
              b0          <= b1;
              b1          <= io.in_data;
            end else begin
              if (buf_cnt == 2'd0) b0 <= io.in_data;
              else                 b1 <= io.in_data;
              buf_cnt <= buf_cnt + 2'd1;
            end
            // eop with a non-full buffer is a runt: nothing was ejected, just drop it.
            if (io.in_eop) begin
              buf_cnt <= '0;
              state   <= ST_IDLE;
            end
          end
        end
        ST_ABORT: begin
          // Close the half-sent packet with the oldest buffered byte, drop the other.
          if (out_ld) begin
            out_valid_q <= 1'b1;
            out_data_q  <= b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b1;
            out_err_q   <= 1'b1;
            pkt_len_q   <= cnt;
            buf_cnt     <= '0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_strip_r.sv
// Bench for crc16_strip_r: table of short packets plus directed multi-cycle sequences.
// Latency: n/a.
// Backpressure: out_ready driven hold/random/always-on by a mode variable.
module tb_crc16_strip_r;

  logic clk;
  logic rst;

  crc16_strip_r_if #(.CNT_W(11)) io ();

  crc16_strip_r #(.MAX_PAYLOAD(1023), .CNT_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic        err;
    logic [10:0] len;
    logic        chk_len;
  } beat_t;

  typedef struct {
    int         n;
    logic [7:0] b [8];
    bit         auto_crc;
    bit         corrupt;
    bit         exp_err;
    int         exp_len;
    int         exp_beats;
  } vec_t;

  beat_t      exp_q [$];
  beat_t      got_q [$];
  logic [7:0] tx_q  [$];
  int         n_chk = 0;
  int         n_err = 0;
  int         rmode = 0;
  vec_t       vt [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // out_ready: 0 = always ready, 1 = random stalls, 2 = held low
  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       io.out_ready = ($urandom_range(0, 2) != 0);
        2:       io.out_ready = 1'b0;
        default: io.out_ready = 1'b1;
      endcase
    end
  end

  // Capture every transferred output beat
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && io.out_valid && io.out_ready) begin
        beat_t bt;
        bt.d = io.out_data; bt.sop = io.out_sop; bt.eop = io.out_eop;
        bt.err = io.out_err; bt.len = io.pkt_len; bt.chk_len = 1'b0;
        got_q.push_back(bt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic set_rmode(input int m);
    rmode = m;
    @(posedge clk);
    #2;
  endtask

  // Append the transmitted CRC (complement of the register) for tx_q[1..]
  task automatic append_crc(input bit corrupt);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 1; i < tx_q.size(); i++) c = crc_upd(c, tx_q[i]);
    c = ~c;
    if (corrupt) c[0] = ~c[0];
    tx_q.push_back(c[7:0]);
    tx_q.push_back(c[15:8]);
  endtask

  // Reference model for a complete packet held in tx_q
  task automatic build_exp();
    int          n;
    logic [15:0] c;
    logic [15:0] rx;
    beat_t       bt;
    n = tx_q.size();
    if (n < 3) return;
    c = 16'hFFFF;
    for (int i = 1; i <= n - 3; i++) c = crc_upd(c, tx_q[i]);
    rx = {tx_q[n-1], tx_q[n-2]};
    for (int i = 0; i <= n - 3; i++) begin
      bt.d = tx_q[i]; bt.sop = (i == 0); bt.eop = (i == n - 3);
      bt.err = (rx != ~c) || ((n - 3) > 1023);
      bt.len = 11'(n - 3); bt.chk_len = 1'b1;
      exp_q.push_back(bt);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int t;
    t = 0;
    io.in_valid = 1'b1; io.in_data = d; io.in_sop = s; io.in_eop = e;
    @(negedge clk);
    while (!io.in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!io.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0; io.in_sop = 1'b0; io.in_eop = 1'b0;
  endtask

  task automatic send_tx(input bit gaps, input bit with_eop, input int first);
    for (int i = first; i < tx_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_byte(tx_q[i], i == 0, with_eop && (i == tx_q.size() - 1));
    end
  endtask

  task automatic check_out(input string name);
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk({name, "_beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_d%0d", name, i), got_q[i].d, exp_q[i].d);
      chk($sformatf("%s_sop%0d", name, i), got_q[i].sop, exp_q[i].sop);
      chk($sformatf("%s_eop%0d", name, i), got_q[i].eop, exp_q[i].eop);
      if (exp_q[i].eop) begin
        chk({name, "_err"}, got_q[i].err, exp_q[i].err);
        if (exp_q[i].chk_len) chk({name, "_len"}, got_q[i].len, exp_q[i].len);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    beat_t bt;
    vt[0] = '{3, '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 0, 1};
    vt[1] = '{4, '{8'hC3, 8'h00, 8'h40, 8'hBF, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 1, 2};
    vt[2] = '{4, '{8'hC3, 8'h00, 8'h41, 8'hBF, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b1, 1, 2};
    vt[3] = '{2, '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 0, 0};
    vt[4] = '{4, '{8'h4B, 8'h00, 8'h40, 8'hBF, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 1, 2};
    vt[5] = '{1, '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 0, 0};
    vt[6] = '{5, '{8'h4B, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 1'b0, 4, 5};
    vt[7] = '{4, '{8'h87, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1, 1'b1, 3, 4};

    io.in_valid = 1'b0; io.in_sop = 1'b0; io.in_eop = 1'b0; io.in_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", io.out_valid, 1'b0);
    chk("rst_out_sop",   io.out_sop,   1'b0);
    chk("rst_out_eop",   io.out_eop,   1'b0);
    chk("rst_out_err",   io.out_err,   1'b0);
    chk("rst_out_data",  io.out_data,  8'h00);
    chk("rst_pkt_len",   io.pkt_len,   11'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", io.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Table of short packets, hand-derived results
    for (int v = 0; v < 8; v++) begin
      tx_q.delete();
      for (int j = 0; j < vt[v].n; j++) tx_q.push_back(vt[v].b[j]);
      if (vt[v].auto_crc) append_crc(vt[v].corrupt);
      for (int k = 0; k < vt[v].exp_beats; k++) begin
        bt.d = tx_q[k]; bt.sop = (k == 0); bt.eop = (k == vt[v].exp_beats - 1);
        bt.err = vt[v].exp_err; bt.len = 11'(vt[v].exp_len); bt.chk_len = 1'b1;
        exp_q.push_back(bt);
      end
      send_tx(1'b0, 1'b1, 0);
      check_out($sformatf("vec%0d", v));
    end

    // Stray non-sop byte in IDLE is dropped; restart-in-place before anything was emitted
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    tx_q = '{8'hC3, 8'h00, 8'h40, 8'hBF};
    build_exp();
    send_tx(1'b0, 1'b1, 0);
    check_out("restart");

    // 64-byte random payload, input gaps and output stalls
    set_rmode(1);
    tx_q.delete();
    tx_q.push_back(8'h4B);
    for (int i = 0; i < 64; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    append_crc(1'b0);
    build_exp();
    send_tx(1'b1, 1'b1, 0);
    check_out("rand64");
    set_rmode(0);

    // Output held for 5 cycles: output stable, input stalled with a full buffer
    set_rmode(2);
    tx_q.delete();
    for (int i = 0; i < 17; i++) tx_q.push_back(i == 0 ? 8'hC3 : 8'(i));
    append_crc(1'b0);
    build_exp();
    for (int i = 0; i < 3; i++) send_byte(tx_q[i], i == 0, 1'b0);
    io.in_valid = 1'b1; io.in_data = tx_q[3];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_in_ready", io.in_ready, 1'b0);
      chk("hold_valid",    io.out_valid, 1'b1);
      chk("hold_data",     io.out_data, 8'hC3);
      chk("hold_sop",      io.out_sop, 1'b1);
    end
    set_rmode(0);
    send_tx(1'b0, 1'b1, 3);
    check_out("hold");

    // Abort: 5 bytes of an open packet, then a new sop
    tx_q = '{8'hC3, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_tx(1'b0, 1'b0, 0);
    bt = '{d: 8'hC3, sop: 1'b1, eop: 1'b0, err: 1'b0, len: 11'd0, chk_len: 1'b0}; exp_q.push_back(bt);
    bt = '{d: 8'hA1, sop: 1'b0, eop: 1'b0, err: 1'b0, len: 11'd0, chk_len: 1'b0}; exp_q.push_back(bt);
    bt = '{d: 8'hA2, sop: 1'b0, eop: 1'b0, err: 1'b0, len: 11'd0, chk_len: 1'b0}; exp_q.push_back(bt);
    bt = '{d: 8'hA3, sop: 1'b0, eop: 1'b1, err: 1'b1, len: 11'd0, chk_len: 1'b0}; exp_q.push_back(bt);
    tx_q = '{8'h87, 8'h5A, 8'hC7};
    append_crc(1'b0);
    build_exp();
    send_tx(1'b0, 1'b1, 0);
    check_out("abort");

    // Overlength: 1024 payload bytes with a correct CRC
    tx_q.delete();
    tx_q.push_back(8'hC3);
    for (int i = 0; i < 1024; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    append_crc(1'b0);
    build_exp();
    chk("ovl_model_err", exp_q[exp_q.size()-1].err, 1'b1);
    send_tx(1'b0, 1'b1, 0);
    check_out("overlen");

    // Reset in the middle of a packet with a beat waiting in the output register
    set_rmode(2);
    send_byte(8'hC3, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    chk("prerst_valid", io.out_valid, 1'b1);
    chk("prerst_data",  io.out_data, 8'hC3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("postrst_valid", io.out_valid, 1'b0);
    chk("postrst_in_ready", io.in_ready, 1'b1);
    set_rmode(0);
    chk("postrst_nobeats", got_q.size(), 0);
    tx_q = '{8'h4B, 8'h00, 8'h40, 8'hBF};
    build_exp();
    send_tx(1'b0, 1'b1, 0);
    check_out("afterrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
